// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bus: ID/EX/MEM status from the datapath and the
// resulting pipeline-register enables/flushes plus event counters.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [1:0]       id_compare_code;
    logic [1:0]       id_branch_src;
    logic             id_take;
    logic             ex_memread;
    logic             ex_regwrite;
    logic [4:0]       ex_dest;
    logic             mem_memread;
    logic [4:0]       mem_dest;
    logic             mem_access;
    logic             mem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_write;
    logic             memwb_flush;
    logic             mem_fault;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    // Datapath side: supplies stage status, consumes enables and flushes.
    modport master (
        output id_rs, id_rt, id_uses_rt, id_compare_code, id_branch_src, id_take,
        output ex_memread, ex_regwrite, ex_dest,
        output mem_memread, mem_dest, mem_access, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
        input  exmem_write, memwb_flush, mem_fault, stall_count, flush_count
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_compare_code, id_branch_src, id_take,
        input  ex_memread, ex_regwrite, ex_dest,
        input  mem_memread, mem_dest, mem_access, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
        output exmem_write, memwb_flush, mem_fault, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage mips32 pipeline.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  RUN    | normal issue; load-use / branch-operand stalls, taken flushes
//  FREEZE | data memory was busy last cycle; whole pipe held while it stays busy
//  FAULT  | memory watchdog expired; pipe held until reset
//
// Priority: fault > mem-wait > load-use > branch-operand > taken-flush.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic            clock,
    input  logic            reset,
    pipeline_ctrl_if.slave  bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic [CNT_W-1:0]  stallCount;
    logic [CNT_W-1:0]  flushCount;

    logic memWait;
    logic lastWait;
    logic loadUse;
    logic checkRs;
    logic checkRt;
    logic hazRs;
    logic hazRt;
    logic branchHazard;
    logic takeFlush;

    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexWrite;
    logic idexFlush;
    logic exmemWrite;
    logic memwbFlush;
    logic stallEvent;
    logic flushEvent;

    // $0 is hardwired to zero, so it never creates a dependency.
    function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    assign memWait  = bus.mem_access & ~bus.mem_ready;
    assign lastWait = (waitCnt == WAIT_W'(MEM_TIMEOUT - 1));

    assign loadUse = bus.ex_memread &
                     (regMatch(bus.ex_dest, bus.id_rs) |
                      (bus.id_uses_rt & regMatch(bus.ex_dest, bus.id_rt)));

    // beq/bne compare both operands in ID; jr only reads rs; j/jal read nothing.
    assign checkRt = (bus.id_compare_code == 2'b01) | (bus.id_compare_code == 2'b10);
    assign checkRs = checkRt |
                     ((bus.id_compare_code == 2'b11) & (bus.id_branch_src == 2'b10));

    // Operands still in flight: any ALU result in EX, or a load still in MEM.
    assign hazRs = (bus.ex_regwrite & regMatch(bus.ex_dest, bus.id_rs)) |
                   (bus.mem_memread & regMatch(bus.mem_dest, bus.id_rs));
    assign hazRt = (bus.ex_regwrite & regMatch(bus.ex_dest, bus.id_rt)) |
                   (bus.mem_memread & regMatch(bus.mem_dest, bus.id_rt));

    assign branchHazard = (checkRs & hazRs) | (checkRt & hazRt);
    assign takeFlush    = bus.id_take & (bus.id_compare_code != 2'b00);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; the watchdog trips on the MEM_TIMEOUT-th consecutive wait cycle.
    always_comb begin
        stateNext = state;
        case (state)
            RUN, FREEZE: begin
                if (memWait) begin
                    stateNext = lastWait ? FAULT : FREEZE;
                end else begin
                    stateNext = RUN;
                end
            end
            FAULT:   stateNext = FAULT;
            default: stateNext = RUN;
        endcase
    end

    // Output decode in priority order; id_take only matters when nothing stalls.
    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexWrite  = 1'b1;
        idexFlush  = 1'b0;
        exmemWrite = 1'b1;
        memwbFlush = 1'b0;
        stallEvent = 1'b0;
        flushEvent = 1'b0;
        if (state == FAULT) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbFlush = 1'b1;
        end else if (memWait) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbFlush = 1'b1;
            stallEvent = 1'b1;
        end else if (loadUse || branchHazard) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexFlush  = 1'b1;
            stallEvent = 1'b1;
        end else if (takeFlush) begin
            ifidFlush  = 1'b1;
            flushEvent = 1'b1;
        end
    end

    // Consecutive mem-wait cycles; frozen in FAULT so the count that tripped is kept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            waitCnt <= '0;
        end else if (state != FAULT) begin
            waitCnt <= memWait ? (waitCnt + WAIT_W'(1)) : '0;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (stallEvent && (stallCount != '1)) begin
                stallCount <= stallCount + CNT_W'(1);
            end
            if (flushEvent && (flushCount != '1)) begin
                flushCount <= flushCount + CNT_W'(1);
            end
        end
    end

    // Reset forces every enable and flush low without waiting for a clock.
    assign bus.pc_write    = pcWrite    & reset;
    assign bus.ifid_write  = ifidWrite  & reset;
    assign bus.ifid_flush  = ifidFlush  & reset;
    assign bus.idex_write  = idexWrite  & reset;
    assign bus.idex_flush  = idexFlush  & reset;
    assign bus.exmem_write = exmemWrite & reset;
    assign bus.memwb_flush = memwbFlush & reset;
    assign bus.mem_fault   = (state == FAULT) & reset;
    assign bus.stall_count = stallCount;
    assign bus.flush_count = flushCount;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage mips32 pipeline.
- Sits beside the ID-stage decoder and drives the write enables and flushes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards and operand hazards on branches resolved in ID, flushes after taken branches and jumps, and freezes the pipeline while data memory is not ready.
- Includes a memory watchdog and saturating stall/flush event counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles on a data-memory access before fault
CNT_W, 16, width of stall/flush event counters

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
id_compare_code  in  2  00 none, 01 beq, 10 bne, 11 j/jal/jr
id_branch_src  in  2  00 pc+imm, 01 imm26, 10 register (jr)
id_take  in  1  ID comparator result; branch/jump taken
ex_memread  in  1  EX instruction is a load
ex_regwrite  in  1  EX instruction writes a register
ex_dest  in  5  destination register of EX instruction
mem_memread  in  1  MEM instruction is a load
mem_dest  in  5  destination register of MEM instruction
mem_access  in  1  MEM instruction reads or writes data memory
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  clear IF/ID to nop
idex_write  out  1  ID/EX load enable
idex_flush  out  1  load nop into ID/EX
exmem_write  out  1  EX/MEM load enable
memwb_flush  out  1  load nop into MEM/WB
mem_fault  out  1  sticky watchdog fault
stall_count  out  CNT_W  saturating count of stall and freeze cycles
flush_count  out  CNT_W  saturating count of taken-branch flushes

Behaviour:
- FSM states: RUN, FREEZE, FAULT. Reset enters RUN. stall_count=0, flush_count=0, mem_fault=0, wait counter=0.
- While reset is low, all outputs are combinationally safe: pc_write, ifid_write, idex_write and exmem_write are 0; all flush outputs are 0.
- Register x matches only when it is nonzero and equal; $0 never causes a hazard.
- Priority each cycle is: fault, then mem-wait, then load-use, then branch-operand, then taken-flush.
- mem-wait condition: mem_access & !mem_ready.
  - RUN moves to FREEZE. FREEZE stays in FREEZE while the condition holds.
  - In FREEZE, or in RUN with the condition true: pc_write, ifid_write, idex_write and exmem_write are 0; memwb_flush=1; all other flushes are 0.
  - The wait counter increments each cycle the condition holds.
  - When mem_ready=1, the cycle proceeds normally: all enables 1, unless a lower-priority rule applies. The FSM returns to RUN and the wait counter clears.
- Watchdog: if the wait counter reaches MEM_TIMEOUT, the FSM goes to FAULT.
  - FAULT: mem_fault=1; all enables 0; memwb_flush=1.
  - FAULT exits only on reset.
- load-use: ex_memread and ex_dest matches id_rs, or matches id_rt when id_uses_rt=1.
  - Response: pc_write=0, ifid_write=0, idex_flush=1; exmem_write=1. Lasts 1 cycle per occurrence.
- branch-operand: id_compare_code is 01 or 10 and the hazard involves rs or rt. For 11 with id_branch_src=10 (jr), only rs is checked.
  - Hazard sources: (ex_regwrite and ex_dest matches) or (mem_memread and mem_dest matches).
  - Response: same as load-use. Repeats every cycle while true, so a load directly feeding a branch stalls 2 cycles.
- taken-flush: id_take=1 and id_compare_code!=00 with no stall of higher priority.
  - Response: ifid_flush=1; all enables 1; flush_count += 1.
  - id_take is ignored during any stall or freeze.
- stall_count increments on every cycle with pc_write=0 (load-use, branch-operand, FREEZE, mem-wait), except in FAULT and reset.
- Both counters saturate at all-ones, with no wrap.
- Simultaneous mem-wait and load-use: freeze only. The load-use stall is re-evaluated on the cycle the memory completes.
- Reset mid-FREEZE or in FAULT: immediate return to RUN with counters and flag cleared.

Test Plan:
1. lw $2 in EX (ex_memread=1, ex_dest=2), ID reads rs=2 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_count=1; next cycle all enables 1.
2. beq rs=3 with lw $3 in EX -> 2 stall cycles (EX match, then mem_memread match), then id_take=1 -> ifid_flush=1, flush_count=1.
3. mem_access=1, mem_ready=0 for 3 cycles, then 1 -> 3 cycles with all enables 0 and memwb_flush=1; stall_count=3; FSM back in RUN.
4. mem_ready held 0 for MEM_TIMEOUT=16 cycles -> mem_fault=1, enables 0; stays until reset low; after reset, mem_fault=0 and counters 0.
5. ex_dest=0 with ex_memread=1 and id_rs=0 -> no stall; jr rs=31 with ex_regwrite=1 and ex_dest=31 -> stall; id_uses_rt=0 with an rt-only match -> no stall.
6. Force CNT_W=4, issue 20 taken jumps -> flush_count saturates at 15.
